tile_spawner: RTL and testbench

- Places the new random tile after every successful slide of the 2048 board. It serves the generate-random-tile state of the game controller.
- On a start pulse it scans the 16-cell board and counts the empty cells. It then picks one empty cell near-uniformly and chooses the tile value: 2 (90 %) or 4 (10 %).
- It reports the chosen cell index and value. The controller writes them into its matrix.
- A free-running LFSR supplies randomness, so the entropy comes from when the player presses keys.

---
 rtl/game2048_pkg.sv | 27 ++
 rtl/tile_spawner_if.sv | 21 ++
 rtl/lfsr16.sv | 21 ++
 rtl/tile_spawner.sv | 147 ++++++++++++++
 tb/tb_tile_spawner.sv | 148 ++++++++++++++
 5 files changed

// File: rtl/game2048_pkg.sv
// Shared 2048 board constants, cell-index helpers and the tile spawner state encoding.
package game2048_pkg;

    localparam int        N_CELLS = 16;
    localparam int        CELL_W  = 4;
    localparam logic [3:0] EMPTY   = 4'd0;
    localparam logic [3:0] TILE_2  = 4'd1;
    localparam logic [3:0] TILE_4  = 4'd2;
    localparam logic [3:0] WIN_EXP = 4'd11;

    typedef enum logic [2:0] {
        SP_IDLE   = 3'd0,
        SP_COUNT  = 3'd1,
        SP_PICK   = 3'd2,
        SP_SELECT = 3'd3,
        SP_DONE   = 3'd4
    } spawn_state_e;

    function automatic logic [1:0] cell_row(input logic [3:0] idx);
        return idx[3:2];
    endfunction

    function automatic logic [1:0] cell_col(input logic [3:0] idx);
        return idx[1:0];
    endfunction

endpackage

// File: rtl/tile_spawner_if.sv
// Request/result bundle between the game controller (master) and the tile spawner (slave).
interface tile_spawner_if;
    logic        start;
    logic [63:0] mat_flat;
    logic        busy;
    logic        done;
    logic        valid;
    logic        full;
    logic [3:0]  cell_idx;
    logic [3:0]  cell_val;

    modport master (
        output start, mat_flat,
        input  busy, done, valid, full, cell_idx, cell_val
    );

    modport slave (
        input  start, mat_flat,
        output busy, done, valid, full, cell_idx, cell_val
    );
endinterface

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR (taps 16,14,13,11); a zero seed is forced to 1.
module lfsr16 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] seed,
    output logic [15:0] q
);
    logic [15:0] seed_safe;
    logic        feedback;

    assign seed_safe = (seed == 16'd0) ? 16'h0001 : seed;
    assign feedback  = q[15] ^ q[13] ^ q[12] ^ q[10];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= seed_safe;
        end else begin
            q <= {q[14:0], feedback};
        end
    end
endmodule

// File: rtl/tile_spawner.sv
// Picks a near-uniform empty cell and a 2/4 tile value; fixed 34-cycle latency (18 when full).
module tile_spawner
    import game2048_pkg::*;
#(
    parameter logic [15:0] SEED      = 16'hACE1,
    parameter logic [7:0]  P4_THRESH = 8'd26
) (
    input  logic           clk,
    input  logic           rst_n,
    tile_spawner_if.slave  sp
);
    spawn_state_e state_q, state_d;
    logic [3:0]   scan_q, scan_d;
    logic [4:0]   cnt_q, cnt_d;
    logic [4:0]   seen_q, seen_d;
    logic [4:0]   target_q, target_d;
    logic [15:0]  rnd_q, rnd_d;
    logic         valid_q, valid_d;
    logic         full_q, full_d;
    logic [3:0]   idx_q, idx_d;
    logic [3:0]   val_q, val_d;

    logic [15:0]  lfsr_q;
    logic [N_CELLS-1:0] cell_empty;
    logic         cur_empty;
    logic [12:0]  prod;

    lfsr16 u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .seed  (SEED),
        .q     (lfsr_q)
    );

    generate
        for (genvar gi = 0; gi < N_CELLS; gi++) begin : g_empty
            assign cell_empty[gi] = (sp.mat_flat[CELL_W*gi +: CELL_W] == EMPTY);
        end
    endgenerate

    assign cur_empty = cell_empty[scan_q];
    // Scaling an 8-bit fraction by the count keeps the target in 0..cnt-1.
    assign prod      = {5'd0, rnd_q[7:0]} * {8'd0, cnt_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= SP_IDLE;
            scan_q   <= '0;
            cnt_q    <= '0;
            seen_q   <= '0;
            target_q <= '0;
            rnd_q    <= '0;
            valid_q  <= 1'b0;
            full_q   <= 1'b0;
            idx_q    <= '0;
            val_q    <= '0;
        end else begin
            state_q  <= state_d;
            scan_q   <= scan_d;
            cnt_q    <= cnt_d;
            seen_q   <= seen_d;
            target_q <= target_d;
            rnd_q    <= rnd_d;
            valid_q  <= valid_d;
            full_q   <= full_d;
            idx_q    <= idx_d;
            val_q    <= val_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        scan_d   = scan_q;
        cnt_d    = cnt_q;
        seen_d   = seen_q;
        target_d = target_q;
        rnd_d    = rnd_q;
        valid_d  = valid_q;
        full_d   = full_q;
        idx_d    = idx_q;
        val_d    = val_q;

        case (state_q)
            SP_IDLE: begin
                if (sp.start) begin
                    state_d = SP_COUNT;
                    scan_d  = '0;
                    cnt_d   = '0;
                    rnd_d   = lfsr_q;
                    valid_d = 1'b0;
                    full_d  = 1'b0;
                    idx_d   = '0;
                    val_d   = '0;
                end
            end
            SP_COUNT: begin
                if (cur_empty) begin
                    cnt_d = cnt_q + 5'd1;
                end
                scan_d = scan_q + 4'd1;
                if (scan_q == 4'd15) begin
                    state_d = SP_PICK;
                end
            end
            SP_PICK: begin
                if (cnt_q == 5'd0) begin
                    state_d = SP_DONE;
                    full_d  = 1'b1;
                    valid_d = 1'b0;
                end else begin
                    state_d  = SP_SELECT;
                    target_d = prod[12:8];
                    scan_d   = '0;
                    seen_d   = '0;
                end
            end
            SP_SELECT: begin
                // Walk the whole board even after the match so latency never depends on data.
                if (cur_empty) begin
                    if (seen_q == target_q) begin
                        idx_d = scan_q;
                    end
                    seen_d = seen_q + 5'd1;
                end
                scan_d = scan_q + 4'd1;
                if (scan_q == 4'd15) begin
                    state_d = SP_DONE;
                    valid_d = 1'b1;
                    val_d   = (rnd_q[15:8] < P4_THRESH) ? TILE_4 : TILE_2;
                end
            end
            SP_DONE: begin
                state_d = SP_IDLE;
            end
            default: begin
                state_d = SP_IDLE;
            end
        endcase
    end

    assign sp.busy     = (state_q == SP_COUNT) || (state_q == SP_PICK) || (state_q == SP_SELECT);
    assign sp.done     = (state_q == SP_DONE);
    assign sp.valid    = valid_q;
    assign sp.full     = full_q;
    assign sp.cell_idx = idx_q;
    assign sp.cell_val = val_q;
endmodule

// File: tb/tb_tile_spawner.sv
// Directed bench for tile_spawner: reference LFSR drives exact expected cell/value per operation.
module tb_tile_spawner;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;
    logic [15:0] m_lfsr;

    tile_spawner_if sp_if ();

    tile_spawner #(
        .SEED      (16'hACE1),
        .P4_THRESH (8'd26)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sp    (sp_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_lfsr <= 16'hACE1;
        else        m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; issues one start and follows the operation to idle.
    task automatic run_op(input logic [63:0] board, input bit extra_starts);
        logic [15:0] rnd;
        int cnt, target, seen, exp_idx, exp_val, exp_lat;
        int lat, ndone, busy_cnt;
        cnt = 0; seen = 0; exp_idx = 0;
        for (int i = 0; i < 16; i++) if (board[4*i +: 4] == 4'd0) cnt++;
        sp_if.mat_flat = board;
        rnd = m_lfsr;
        target  = (int'(rnd[7:0]) * cnt) >> 8;
        for (int i = 0; i < 16; i++) begin
            if (board[4*i +: 4] == 4'd0) begin
                if (seen == target) exp_idx = i;
                seen++;
            end
        end
        exp_val = (cnt == 0) ? 0 : ((rnd[15:8] < 8'd26) ? 2 : 1);
        exp_lat = (cnt == 0) ? 18 : 34;
        lat = 0; ndone = 0; busy_cnt = 0;
        sp_if.start = 1'b1;
        @(negedge clk);
        for (int c = 1; c <= 60; c++) begin
            sp_if.start = (extra_starts && c == 5) ? 1'b1 : 1'b0;
            if (sp_if.done) begin
                if (lat == 0) lat = c;
                ndone++;
                if (extra_starts) sp_if.start = 1'b1;
                chk_eq("valid", 32'(sp_if.valid), 32'(cnt != 0));
                chk_eq("full", 32'(sp_if.full), 32'(cnt == 0));
                chk_eq("cell_idx", 32'(sp_if.cell_idx), 32'(exp_idx));
                chk_eq("cell_val", 32'(sp_if.cell_val), 32'(exp_val));
            end
            if (sp_if.busy) busy_cnt++;
            if (lat != 0 && c == lat + 2) chk_eq("hold_valid", 32'(sp_if.valid), 32'(cnt != 0));
            if (lat != 0 && c == lat + 3) break;
            @(negedge clk);
        end
        sp_if.start = 1'b0;
        chk_eq("latency", 32'(lat), 32'(exp_lat));
        chk_eq("done_pulses", 32'(ndone), 32'd1);
        chk_eq("busy_cycles", 32'(busy_cnt), 32'(exp_lat - 1));
        $display("op board=%016h rnd=%04h lat=%0d idx=%0d val=%0d full=%0b", board, rnd, lat,
                 sp_if.cell_idx, sp_if.cell_val, sp_if.full);
    endtask

    task automatic chk_all_zero(input string tag);
        chk_eq({tag, "_busy"}, 32'(sp_if.busy), 32'd0);
        chk_eq({tag, "_done"}, 32'(sp_if.done), 32'd0);
        chk_eq({tag, "_valid"}, 32'(sp_if.valid), 32'd0);
        chk_eq({tag, "_full"}, 32'(sp_if.full), 32'd0);
        chk_eq({tag, "_idx"}, 32'(sp_if.cell_idx), 32'd0);
        chk_eq({tag, "_val"}, 32'(sp_if.cell_val), 32'd0);
    endtask

    initial begin
        logic [63:0] board;
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        sp_if.start = 1'b0;
        sp_if.mat_flat = 64'd0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;

        // First start right after reset: rnd=ACE1, 16 empty -> target 0xE1*16>>8=14, 0xAC>=26 -> tile 2.
        run_op(64'd0, 1'b0);
        chk_eq("seed_idx", 32'(sp_if.cell_idx), 32'd14);
        chk_eq("seed_val", 32'(sp_if.cell_val), 32'd1);

        for (int k = 0; k < 200; k++) begin
            repeat ($urandom_range(0, 7)) @(negedge clk);
            run_op(64'h1111_1101_1111_1111, 1'b0);
            chk_eq("only9_idx", 32'(sp_if.cell_idx), 32'd9);
        end

        run_op(64'h1111_1111_1111_1111, 1'b1);
        chk_eq("full_board", 32'(sp_if.full), 32'd1);
        run_op(64'h0000_0000_0000_0000, 1'b1);
        run_op(64'h0120_3004_0500_0061, 1'b1);
        run_op(64'hB000_0000_0000_0000, 1'b0);
        run_op(64'h0FFF_FFFF_FFFF_FFFF, 1'b0);
        chk_eq("last_empty_idx", 32'(sp_if.cell_idx), 32'd15);

        for (int k = 0; k < 100; k++) begin
            board = {$urandom, $urandom} & {$urandom, $urandom};
            repeat ($urandom_range(0, 5)) @(negedge clk);
            run_op(board, (k % 4) == 0);
        end

        // Reset in the middle of SELECT: outputs drop immediately, no done pulse.
        sp_if.mat_flat = 64'd0;
        sp_if.start = 1'b1;
        @(negedge clk);
        sp_if.start = 1'b0;
        repeat (19) @(negedge clk);
        chk_eq("pre_rst_busy", 32'(sp_if.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk_all_zero("midrst");
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk_eq("midrst_no_done", 32'(sp_if.done), 32'd0);
        end
        rst_n = 1'b1;
        run_op(64'd0, 1'b0);
        chk_eq("rst_seed_idx", 32'(sp_if.cell_idx), 32'd14);
        chk_eq("rst_seed_val", 32'(sp_if.cell_val), 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
